// File: rtl/cpu_control.sv
// cpu_control: four-state instruction sequencer (FETCH, DECODE, EXEC, WB)
// placed directly upstream of the 8x8 register file. It accepts one
// instruction per FETCH handshake and drives the read addresses, ALU/mux
// controls and a one-cycle write-back strobe. It also maintains the PC.
//
// Ports:
//   CLK          rising-edge clock
//   RESET        asynchronous active-low reset
//   INSTRUCTION  instruction word: opcode[31:24] dest[18:16] src1[10:8]
//                src2[2:0] immediate[7:0]
//   INSTR_VALID  INSTRUCTION is valid (sampled only in FETCH)
//   INSTR_READY  high while in FETCH
//   PC           address of the next instruction to fetch
//   OUT1ADDRESS  register-file read port 1 address (src1)
//   OUT2ADDRESS  register-file read port 2 address (src2)
//   INADDRESS    register-file write address (dest)
//   WRITE        register-file write enable, one cycle in WB
//   ALUOP        000 forward, 001 add, 010 and, 011 or
//   IMMEDIATE    immediate field of the held instruction
//   MUX_IMM      ALU operand 2 comes from IMMEDIATE
//   MUX_NEG      ALU operand 2 is negated (sub)
//   ERROR        sticky illegal-opcode flag
module cpu_control #(
  parameter int unsigned         PC_WIDTH = 32,
  parameter int unsigned         PC_STEP  = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [31:0]         INSTRUCTION,
  input  logic                INSTR_VALID,
  output logic                INSTR_READY,
  output logic [PC_WIDTH-1:0] PC,
  output logic [2:0]          OUT1ADDRESS,
  output logic [2:0]          OUT2ADDRESS,
  output logic [2:0]          INADDRESS,
  output logic                WRITE,
  output logic [2:0]          ALUOP,
  output logic [7:0]          IMMEDIATE,
  output logic                MUX_IMM,
  output logic                MUX_NEG,
  output logic                ERROR
);

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;

  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  state_t              state;
  logic [31:0]         ir;
  logic [PC_WIDTH-1:0] pc_next;

  logic                dec_legal;
  logic [2:0]          dec_aluop;
  logic                dec_imm;
  logic                dec_neg;

  // Only the opcode and dest fields are consumed after the accept edge;
  // the read addresses and immediate are captured directly from INSTRUCTION.
  logic unused_ir_bits;
  assign unused_ir_bits = ^{ir[23:19], ir[15:0]};

  // PC increment wraps modulo 2^PC_WIDTH
  assign pc_next = PC + PC_WIDTH'(PC_STEP);

  // Opcode decode of the held instruction
  always_comb begin
    dec_legal = 1'b1;
    dec_aluop = ALU_FWD;
    dec_imm   = 1'b0;
    dec_neg   = 1'b0;
    case (ir[31:24])
      OP_LOADI: dec_imm   = 1'b1;
      OP_MOV:   dec_aluop = ALU_FWD;
      OP_ADD:   dec_aluop = ALU_ADD;
      OP_SUB: begin
        dec_aluop = ALU_ADD;
        dec_neg   = 1'b1;
      end
      OP_AND:   dec_aluop = ALU_AND;
      OP_OR:    dec_aluop = ALU_OR;
      default:  dec_legal = 1'b0;
    endcase
  end

  // Sequencer: state and every output are updated together, so each output
  // already reflects the state being entered.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= FETCH;
      ir          <= '0;
      PC          <= RESET_PC;
      INSTR_READY <= 1'b1;
      OUT1ADDRESS <= '0;
      OUT2ADDRESS <= '0;
      INADDRESS   <= '0;
      WRITE       <= 1'b0;
      ALUOP       <= '0;
      IMMEDIATE   <= '0;
      MUX_IMM     <= 1'b0;
      MUX_NEG     <= 1'b0;
      ERROR       <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (INSTR_VALID) begin
            // Read addresses must be valid for the whole DECODE cycle
            ir          <= INSTRUCTION;
            OUT1ADDRESS <= INSTRUCTION[10:8];
            OUT2ADDRESS <= INSTRUCTION[2:0];
            IMMEDIATE   <= INSTRUCTION[7:0];
            INSTR_READY <= 1'b0;
            state       <= DECODE;
          end
        end
        DECODE: begin
          if (dec_legal) begin
            ALUOP   <= dec_aluop;
            MUX_IMM <= dec_imm;
            MUX_NEG <= dec_neg;
            state   <= EXEC;
          end else begin
            // Illegal opcode retires without write-back
            ERROR       <= 1'b1;
            PC          <= pc_next;
            INSTR_READY <= 1'b1;
            state       <= FETCH;
          end
        end
        EXEC: begin
          WRITE     <= 1'b1;
          INADDRESS <= ir[18:16];
          state     <= WB;
        end
        WB: begin
          WRITE       <= 1'b0;
          PC          <= pc_next;
          INSTR_READY <= 1'b1;
          state       <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_control.sv
// tb_cpu_control: randomized self-checking bench for cpu_control with a
// per-instruction reference model (expected PC, sticky error, opcode table).
module tb_cpu_control;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] INSTRUCTION;
  logic        INSTR_VALID;
  logic        INSTR_READY;
  logic [31:0] PC;
  logic [2:0]  OUT1ADDRESS, OUT2ADDRESS, INADDRESS, ALUOP;
  logic        WRITE, MUX_IMM, MUX_NEG, ERROR;
  logic [7:0]  IMMEDIATE;

  // Second instance with a reset PC just below the wrap point
  logic [31:0] instr2;
  logic        valid2;
  logic        ready2;
  logic [31:0] pc2;
  logic [2:0]  o1_2, o2_2, in_2, alu_2;
  logic        write2, mimm2, mneg2, err2;
  logic [7:0]  imm2;

  always #5 CLK = ~CLK;

  cpu_control dut (
    .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION),
    .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY), .PC(PC),
    .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
    .INADDRESS(INADDRESS), .WRITE(WRITE), .ALUOP(ALUOP),
    .IMMEDIATE(IMMEDIATE), .MUX_IMM(MUX_IMM), .MUX_NEG(MUX_NEG),
    .ERROR(ERROR)
  );

  cpu_control #(.PC_WIDTH(32), .PC_STEP(4), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .CLK(CLK), .RESET(RESET), .INSTRUCTION(instr2),
    .INSTR_VALID(valid2), .INSTR_READY(ready2), .PC(pc2),
    .OUT1ADDRESS(o1_2), .OUT2ADDRESS(o2_2), .INADDRESS(in_2),
    .WRITE(write2), .ALUOP(alu_2), .IMMEDIATE(imm2),
    .MUX_IMM(mimm2), .MUX_NEG(mneg2), .ERROR(err2)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] exp_pc;
  logic        exp_err;
  // ALU code per legal opcode 0..5 (entries 6,7 unused)
  logic [2:0]  alu_tab [8] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd0, 3'd0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".pc"},    PC, 32'h0);
    check({tag, ".ready"}, 32'(INSTR_READY), 32'd1);
    check({tag, ".write"}, 32'(WRITE), 32'd0);
    check({tag, ".error"}, 32'(ERROR), 32'd0);
    check({tag, ".aluop"}, 32'(ALUOP), 32'd0);
    check({tag, ".mimm"},  32'(MUX_IMM), 32'd0);
    check({tag, ".mneg"},  32'(MUX_NEG), 32'd0);
    check({tag, ".addr"},  32'({OUT1ADDRESS, OUT2ADDRESS, INADDRESS}), 32'd0);
    check({tag, ".imm"},   32'(IMMEDIATE), 32'd0);
    check({tag, ".pc2"},   pc2, 32'hFFFF_FFFC);
  endtask

  task automatic check_fetch(input string tag);
    check({tag, ".ready"}, 32'(INSTR_READY), 32'd1);
    check({tag, ".write"}, 32'(WRITE), 32'd0);
    check({tag, ".pc"},    PC, exp_pc);
    check({tag, ".error"}, 32'(ERROR), 32'(exp_err));
  endtask

  // Asynchronous reset between clock edges; returns at a FETCH negedge
  task automatic do_reset();
    #2 RESET = 1'b0;
    #1 check_reset_values("async_rst");
    @(negedge CLK);
    RESET       = 1'b1;
    INSTR_VALID = 1'b0;
    exp_pc      = 32'h0;
    exp_err     = 1'b0;
    check_fetch("post_rst");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      INSTR_VALID = 1'b0;
      INSTRUCTION = $urandom;
      @(negedge CLK);
      check_fetch("idle");
    end
  endtask

  // Issue one instruction from a FETCH negedge; returns at the next FETCH
  // negedge. abort_at: 0 none, 1 DECODE, 2 EXEC, 3 WB.
  task automatic run_instr(input logic [31:0] ins, input bit hold, input int abort_at);
    logic [7:0] op;
    bit         legal;
    op    = ins[31:24];
    legal = (op < 8'd6);
    check_fetch("fetch");
    INSTRUCTION = ins;
    INSTR_VALID = 1'b1;
    @(negedge CLK);
    // DECODE: inputs are garbage and must be ignored
    INSTRUCTION = $urandom;
    INSTR_VALID = hold ? 1'b1 : 1'($urandom);
    check("dec.ready", 32'(INSTR_READY), 32'd0);
    check("dec.write", 32'(WRITE), 32'd0);
    check("dec.out1",  32'(OUT1ADDRESS), 32'(ins[10:8]));
    check("dec.out2",  32'(OUT2ADDRESS), 32'(ins[2:0]));
    check("dec.imm",   32'(IMMEDIATE), 32'(ins[7:0]));
    check("dec.error", 32'(ERROR), 32'(exp_err));
    check("dec.pc",    PC, exp_pc);
    if (abort_at == 1) begin do_reset(); return; end
    @(negedge CLK);
    if (!legal) begin
      exp_err = 1'b1;
      exp_pc  = exp_pc + 32'd4;
      check_fetch("illegal");
      return;
    end
    // EXEC
    INSTRUCTION = $urandom;
    INSTR_VALID = hold ? 1'b1 : 1'($urandom);
    check("ex.write", 32'(WRITE), 32'd0);
    check("ex.ready", 32'(INSTR_READY), 32'd0);
    check("ex.aluop", 32'(ALUOP), 32'(alu_tab[op[2:0]]));
    check("ex.mimm",  32'(MUX_IMM), 32'(op == 8'h00));
    check("ex.mneg",  32'(MUX_NEG), 32'(op == 8'h03));
    check("ex.hold",  32'({OUT1ADDRESS, OUT2ADDRESS, IMMEDIATE}),
                      32'({ins[10:8], ins[2:0], ins[7:0]}));
    check("ex.error", 32'(ERROR), 32'(exp_err));
    if (abort_at == 2) begin do_reset(); return; end
    @(negedge CLK);
    // WB
    INSTRUCTION = $urandom;
    INSTR_VALID = hold ? 1'b1 : 1'b0;
    check("wb.write", 32'(WRITE), 32'd1);
    check("wb.inaddr", 32'(INADDRESS), 32'(ins[18:16]));
    check("wb.aluop", 32'(ALUOP), 32'(alu_tab[op[2:0]]));
    check("wb.mimm",  32'(MUX_IMM), 32'(op == 8'h00));
    check("wb.mneg",  32'(MUX_NEG), 32'(op == 8'h03));
    check("wb.pc",    PC, exp_pc);
    if (abort_at == 3) begin do_reset(); return; end
    @(negedge CLK);
    exp_pc = exp_pc + 32'd4;
    check_fetch("retire");
  endtask

  initial begin
    logic [7:0]  op;
    logic [31:0] ins;
    int          ab;
    RESET       = 1'b0;
    INSTRUCTION = 32'h0;
    INSTR_VALID = 1'b0;
    instr2      = 32'h0;
    valid2      = 1'b0;
    exp_pc      = 32'h0;
    exp_err     = 1'b0;
    repeat (2) @(negedge CLK);
    check_reset_values("reset");
    RESET = 1'b1;
    @(negedge CLK);
    check_fetch("after_release");

    // PC wrap on the high-reset-PC instance
    check("wrap.pc0", pc2, 32'hFFFF_FFFC);
    instr2 = 32'h0003_0011;
    valid2 = 1'b1;
    @(negedge CLK);
    valid2 = 1'b0;
    repeat (2) @(negedge CLK);
    check("wrap.write", 32'(write2), 32'd1);
    @(negedge CLK);
    check("wrap.pc1", pc2, 32'h0);
    check("wrap.write_off", 32'(write2), 32'd0);
    check_fetch("main_idle_during_wrap");

    // Directed sequence
    run_instr(32'h0005_002A, 1'b1, 0);   // loadi r5, 0x2A
    run_instr(32'h0202_0503, 1'b1, 0);   // add r2, r5, r3
    run_instr(32'h0301_0203, 1'b1, 0);   // sub, back-to-back
    run_instr(32'h0504_0607, 1'b1, 0);   // or, back-to-back
    run_instr(32'h0700_0000, 1'b0, 0);   // illegal opcode
    run_instr(32'h0206_0102, 1'b0, 0);   // add with error still set
    run_instr(32'h0201_0102, 1'b0, 2);   // reset during EXEC
    idle(10);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      op  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(6, 255))
                                        : 8'($urandom_range(0, 5));
      ins = {op, 5'($urandom), 3'($urandom), 5'($urandom), 3'($urandom), 8'($urandom)};
      ab  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_instr(ins, 1'($urandom), ab);
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/cpu_control.md
Name: cpu_control

Overview:
- Multi-cycle instruction sequencer that sits directly upstream of the 8x8 register file.
- Accepts one 32-bit instruction per handshake and decodes it.
- Drives the register-file read addresses, ALU operation and operand-mux selects, then a single-cycle write-back strobe with destination address.
- Maintains the program counter; one instruction retires every 4 cycles.

Parameters:
PC_WIDTH, 32, program counter width
PC_STEP, 4, PC increment per retired or rejected instruction
RESET_PC, 0, PC value loaded on reset

Ports:
CLK  input  1  rising-edge clock
RESET  input  1  asynchronous, active-low reset
INSTRUCTION  input  32  instruction word; fields: opcode[31:24], dest[18:16], src1[10:8], src2[2:0], immediate[7:0]
INSTR_VALID  input  1  INSTRUCTION is valid
INSTR_READY  output  1  sequencer can accept an instruction
PC  output  PC_WIDTH  address of the next instruction to fetch
OUT1ADDRESS  output  3  register-file read port 1 address (src1)
OUT2ADDRESS  output  3  register-file read port 2 address (src2)
INADDRESS  output  3  register-file write address (dest)
WRITE  output  1  register-file write enable
ALUOP  output  3  000 forward, 001 add, 010 and, 011 or
IMMEDIATE  output  8  immediate field of the held instruction
MUX_IMM  output  1  1: ALU operand 2 = IMMEDIATE; 0: register data
MUX_NEG  output  1  1: ALU operand 2 is two's-complemented (sub)
ERROR  output  1  sticky illegal-opcode flag

Behaviour:
- All outputs are registered (Moore), decoded from the state register and a 32-bit instruction register IR.
- States: FETCH, DECODE, EXEC, WB.
- Reset (RESET=0, any time, asynchronous):
  - state=FETCH, IR=0, PC=RESET_PC.
  - WRITE=0, ERROR=0, ALUOP=0, MUX_IMM=0, MUX_NEG=0.
  - All addresses=0, IMMEDIATE=0.
  - INSTR_READY=1 while in FETCH, including directly after reset release.
- FETCH:
  - INSTR_READY=1.
  - At a rising edge with INSTR_VALID=1: IR<=INSTRUCTION, go to DECODE.
  - Otherwise stay in FETCH; PC holds.
- DECODE (1 cycle):
  - INSTR_READY=0.
  - OUT1ADDRESS=IR[10:8], OUT2ADDRESS=IR[2:0], IMMEDIATE=IR[7:0].
  - Gives the register file's 2-unit read delay a full cycle to settle.
- Opcode decode:
  - 0x00 loadi: ALUOP 000, MUX_IMM 1
  - 0x01 mov: ALUOP 000, MUX_IMM 0
  - 0x02 add: ALUOP 001
  - 0x03 sub: ALUOP 001, MUX_NEG 1
  - 0x04 and: ALUOP 010
  - 0x05 or: ALUOP 011
- Illegal opcode (any other value):
  - ERROR<=1 and stays 1 until reset.
  - PC<=PC+PC_STEP; go to FETCH. WRITE never asserts for this instruction.
- EXEC (1 cycle):
  - ALUOP, MUX_IMM and MUX_NEG are valid.
  - Read addresses and IMMEDIATE are held stable.
- WB (1 cycle):
  - WRITE=1, INADDRESS=IR[18:16]; ALU and mux controls still held.
  - At the end of the cycle: PC<=PC+PC_STEP (wraps modulo 2^PC_WIDTH), WRITE returns to 0, go to FETCH.
- Strobe and throughput:
  - WRITE is high for exactly one cycle per legal instruction and is never high outside WB.
  - Back-to-back INSTR_VALID gives one instruction per 4 cycles.
  - An instruction is accepted only on the FETCH cycle; INSTRUCTION is ignored in all other states.
- Control hold:
  - ALUOP, MUX_IMM and MUX_NEG hold their last values through FETCH.
  - Consumers qualify them by state; no glitches occur between DECODE and WB.
- Reset mid-instruction:
  - The in-flight instruction is aborted with no WRITE.
  - PC returns to RESET_PC.
  - The next accepted instruction starts from FETCH.

Test Plan:
- Reset, then loadi 0x00_05_00_2A (dest 5, imm 0x2A) with VALID held 1 -> READY drops after accept; WRITE=1 only in cycle 4 with INADDRESS=5, MUX_IMM=1, ALUOP=000, IMMEDIATE=0x2A; PC 0->4.
- add dest2,src1=5,src2=3 (0x02_02_05_03) -> OUT1ADDRESS=5, OUT2ADDRESS=3 from DECODE; ALUOP=001, MUX_NEG=0; single WRITE to address 2; PC=8.
- sub then or back-to-back, VALID held continuously -> two WRITE pulses exactly 4 cycles apart; MUX_NEG=1 only during the sub instruction; PC advances by 8.
- Opcode 0x07 -> ERROR=1 after DECODE; no WRITE pulse; PC+4; ERROR stays 1 through a following legal add; only reset clears it.
- Assert RESET=0 asynchronously in EXEC of an add -> all outputs reach reset values immediately without waiting for a clock edge; no WRITE pulse; PC=0; INSTR_READY=1 after release.
- VALID=0 for 10 cycles in FETCH -> PC, state and WRITE unchanged; RESET_PC=0xFFFFFFFC followed by one legal instruction -> PC wraps to 0.
